// File: rtl/arm_fetch.sv
// Instruction prefetch unit: walks sequential word addresses into a small FIFO feeding arm_core.
// Optional macro ARM_FETCH_PERF_EN adds a 32-bit fetch_count output counting delivered instructions.
module arm_fetch #(
   parameter logic [29:0] RESET_ADDR = 30'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] inst,
   output logic [29:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [29:0] redirect_addr,
   input  logic        halt
`ifdef ARM_FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [29:0] pc;
   } entry_t;

   localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

   state_t      r_state;
   logic [29:0] r_fetch_pc;
   logic [2:0]  r_count;
   entry_t      r_fifo [FIFO_DEPTH];

   logic        w_push;
   logic        w_pop;
   logic [2:0]  w_count_nxt;
   logic [2:0]  w_wr_idx;
   logic [29:0] w_pc_inc;
   logic [29:0] w_next_pc;

   // A redirect kills both the head hand-off and any arriving data on the same edge.
   assign w_pop       = inst_valid && inst_ready && !redirect;
   assign w_push      = (r_state == REQ) && imem_ack && !redirect;
   assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
   assign w_wr_idx    = r_count - {2'b00, w_pop};
   assign w_pc_inc    = r_fetch_pc + 30'd1;
   assign w_next_pc   = redirect ? redirect_addr : r_fetch_pc;

   assign inst_valid = (r_count != 3'd0);
   assign inst       = r_fifo[0].inst;
   assign inst_pc    = r_fifo[0].pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_ADDR;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_ADDR;
      end else begin
         if (redirect)
            r_fetch_pc <= redirect_addr;
         case (r_state)
            IDLE: begin
               if (!halt && (redirect || r_count < DEPTH_C)) begin
                  r_state   <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= w_next_pc;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  if (!redirect)
                     r_fetch_pc <= w_pc_inc;
                  // Back-to-back only while the FIFO still has room after this edge's push/pop.
                  if (!halt && (redirect || w_count_nxt < DEPTH_C)) begin
                     imem_addr <= redirect ? redirect_addr : w_pc_inc;
                  end else begin
                     r_state  <= IDLE;
                     imem_req <= 1'b0;
                  end
               end else if (redirect) begin
                  r_state <= DISCARD;
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  if (!halt) begin
                     r_state   <= REQ;
                     imem_addr <= w_next_pc;
                  end else begin
                     r_state  <= IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            default: begin
               r_state  <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   // Shift FIFO: entry 0 is always the head, so inst/inst_pc need no read mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 3'd0;
         // NOTE: the storage is reset too because the head entry drives inst/inst_pc, which must read 0 after reset.
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_fifo[i] <= '0;
      end else if (redirect) begin
         r_count <= 3'd0;
      end else begin
         r_count <= w_count_nxt;
         if (w_pop)
            for (int i = 0; i < FIFO_DEPTH - 1; i++)
               r_fifo[i] <= r_fifo[i + 1];
         if (w_push)
            for (int i = 0; i < FIFO_DEPTH; i++)
               if (3'(i) == w_wr_idx)
                  r_fifo[i] <= '{inst: imem_data, pc: r_fetch_pc};
      end
   end

`ifdef ARM_FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_count <= 32'd0;
      else if (w_pop)
         fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule
